mesh_term_if_bank: RTL and testbench
====================================

MESH_TERM_IF_BANK -- requirements
Module: mesh_term_if_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_i.
REQ-002 Parameter ROWS, default 4: mesh rows.
REQ-003 Parameter COLUMNS, default 4: mesh columns.
REQ-004 Parameter PAKG_SIZE, default 32: packet width in bits; minimum 24.
REQ-005 Parameter FIFO_DEPTH, default 16: entries per terminal ingress FIFO; power of two, at least 2.
REQ-006 Parameter AF_LEVEL, default FIFO_DEPTH-2: almost-full threshold.
REQ-007 Parameter NUM_TERM, default 2*(ROWS+COLUMNS): terminal count, derived and not overridden.
REQ-008 clk_i  in  1  clock.
REQ-009 rst_i  in  1  asynchronous active-low reset.
REQ-010 push_i  in  NUM_TERM  per-terminal host push strobe.
REQ-011 push_data_i  in  NUM_TERM x PAKG_SIZE  host packets.
REQ-012 full_o / almost_full_o  out  NUM_TERM  ingress level flags.
REQ-013 pndng_i_in_o  out  NUM_TERM  ingress head valid, to mesh pndng_i_in.
REQ-014 data_out_i_in_o  out  NUM_TERM x PAKG_SIZE  ingress head, to mesh data_out_i_in.
REQ-015 popin_i  in  NUM_TERM  mesh consumed the ingress head.
REQ-016 pndng_i / data_out_i  in  NUM_TERM / NUM_TERM x PAKG_SIZE  mesh egress pending and data.
REQ-017 pop_o  out  NUM_TERM  egress pop, to mesh pop.
REQ-018 rx_valid_o / rx_data_o / rx_ready_i  out / out / in  NUM_TERM / NUM_TERM x PAKG_SIZE / NUM_TERM  host receive handshake.
REQ-019 rx_misroute_o  out  NUM_TERM  sticky misroute flag.
REQ-020 drop_cnt_o  out  NUM_TERM x 16  saturating overflow-drop counters.

Function
REQ-021 Packet fields SHALL be: [P-1:P-8] nxt_jmp, [P-9:P-12] row, [P-13:P-16] col, [P-17] mode, remainder payload (P = PAKG_SIZE).
REQ-022 Terminal coordinates SHALL be: t<C gives (0,t+1); C<=t<2C gives (R+1,t-C+1); 2C<=t<2C+R gives (t-2C+1,0); otherwise (t-2C-R+1,C+1).
REQ-023 Ingress SHALL be first-word-fall-through: pndng_i_in_o = not empty; data_out_i_in_o = head.
REQ-024 popin_i while pndng_i_in_o=1 SHALL remove the head at the clock edge; popin_i while empty SHALL be ignored.
REQ-025 Push while not full SHALL be written; head is visible one cycle after the push edge.
REQ-026 Simultaneous push and pop when full SHALL accept both; level is unchanged.
REQ-027 Simultaneous push and popin_i when empty SHALL accept the push and ignore the pop.
REQ-028 Push while full without pop SHALL drop the packet and increment drop_cnt_o, saturating at 16'hFFFF.
REQ-029 full_o SHALL be level==FIFO_DEPTH; almost_full_o SHALL be level>=AF_LEVEL; both registered-state derived.
REQ-030 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
REQ-031 Egress per terminal SHALL be a two-state FSM, RX_EMPTY and RX_FULL.
REQ-032 pop_o SHALL be combinational: pndng_i and (state==RX_EMPTY or rx_ready_i).
REQ-033 On a pop_o edge, data_out_i SHALL be captured into rx_data_o and the FSM SHALL go to or stay in RX_FULL. This gives one-cycle latency.
REQ-034 rx_ready_i in RX_FULL without pop_o SHALL move the FSM to RX_EMPTY.
REQ-035 rx_valid_o SHALL be 1 exactly in RX_FULL; rx_data_o SHALL hold its value while valid and not ready.
REQ-036 rx_misroute_o SHALL set on capture when the row/col fields are not equal to the terminal's coordinates and nxt_jmp is not all-ones (broadcast).
REQ-037 rx_misroute_o SHALL clear only on reset.

Reset
REQ-038 Asserting rst_i SHALL immediately empty all FIFOs and set these outputs: pndng_i_in_o=0, full_o=0, almost_full_o=(AF_LEVEL==0), FSMs=RX_EMPTY, rx_valid_o=0, rx_data_o=0, rx_misroute_o=0, drop_cnt_o=0.
REQ-039 pop_o SHALL be 0 while rst_i is low, regardless of pndng_i.
REQ-040 Reset mid-transfer SHALL discard in-flight packets; there is no replay after deassertion.

Structure
REQ-041 Package mesh_term_pkg SHALL hold the packet field offsets, the broadcast constant 8'hFF, the rx FSM enum, and the function term_coord(t,ROWS,COLUMNS).
REQ-042 The per-terminal FIFO SHALL be sub-module mesh_term_fifo, instanced NUM_TERM times in a generate loop.
REQ-043 Egress FSM and counters SHALL be in the top module.

Verification
REQ-044 Push 16 packets on terminal 0 with no popin -> full_o=1 after the 16th edge; a 17th push makes drop_cnt_o[0]=1 and the head is unchanged.
REQ-045 Full FIFO, push and popin_i same cycle -> full_o stays 1; the next head is the second packet; ordering is preserved after 40 wrap cycles.
REQ-046 pndng_i[3]=1 with data row=0, col=4 and rx_ready_i=0 -> one pop_o pulse; rx_valid_o=1 next cycle; no further pop until rx_ready_i=1.
REQ-047 Terminal 3 captures row=2, col=2 with nxt_jmp!=FF -> rx_misroute_o[3]=1; the same packet with nxt_jmp=FF leaves it 0.
REQ-048 rst_i low mid-burst with 5 entries queued -> pndng_i_in_o=0 and rx_valid_o=0 immediately, before the next clock edge.
REQ-049 Continuous pndng_i with rx_ready_i held 1 -> pop_o every cycle; 100 packets delivered in order with throughput 1 per cycle.

Source files
------------

// File: rtl/mesh_term_pkg.sv
// Shared definitions for the mesh terminal interface bank: packet field
// layout, broadcast marker, receive FSM encoding and terminal coordinates.
package mesh_term_pkg;

   // Field offsets are counted down from the packet MSB so they hold for any width.
   localparam int NXT_JMP_OFS = 0;
   localparam int NXT_JMP_W   = 8;
   localparam int ROW_OFS     = 8;
   localparam int ROW_W       = 4;
   localparam int COL_OFS     = 12;
   localparam int COL_W       = 4;
   localparam int MODE_OFS    = 16;
   localparam int HDR_W       = 17;

   localparam logic [NXT_JMP_W-1:0] BCAST_JMP = 8'hFF;

   typedef enum logic {
      RX_EMPTY = 1'b0,
      RX_FULL  = 1'b1
   } rx_state_e;

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
   } coord_t;

   // Terminals run along the top edge, bottom edge, left edge, then right edge.
   function automatic coord_t term_coord(input int t, input int rows, input int cols);
      coord_t c;
      int     r;
      int     k;
      if (t < cols) begin
         r = 0;
         k = t + 1;
      end else if (t < 2*cols) begin
         r = rows + 1;
         k = t - cols + 1;
      end else if (t < 2*cols + rows) begin
         r = t - 2*cols + 1;
         k = 0;
      end else begin
         r = t - 2*cols - rows + 1;
         k = cols + 1;
      end
      c.row = r[ROW_W-1:0];
      c.col = k[COL_W-1:0];
      return c;
   endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Per-terminal first-word-fall-through ingress FIFO with level flags and a
// drop strobe for pushes that arrive while full with no pop.
module mesh_term_fifo #(
   parameter int PAKG_SIZE  = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [PAKG_SIZE-1:0] data_i,
   input  logic                 pop_i,
   output logic                 pndng_o,
   output logic [PAKG_SIZE-1:0] data_o,
   output logic                 full_o,
   output logic                 almost_full_o,
   output logic                 drop_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LVL_FULL = FIFO_DEPTH[AW:0];
   localparam logic [AW:0] LVL_AF   = AF_LEVEL[AW:0];

   logic [PAKG_SIZE-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr;
   logic [AW:0]          r_rd_ptr;
   logic [AW:0]          w_level;
   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;

   // One extra pointer bit distinguishes full from empty when indices match.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (w_level == LVL_FULL);
   assign w_pop   = pop_i & ~w_empty;
   assign w_push  = push_i & (~w_full | w_pop);

   assign pndng_o       = ~w_empty;
   assign data_o        = r_mem[r_rd_ptr[AW-1:0]];
   assign full_o        = w_full;
   assign almost_full_o = (w_level >= LVL_AF);
   assign drop_o        = push_i & w_full & ~pop_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/mesh_term_if_bank.sv
// Host-side terminal bank around a mesh: per-terminal ingress FIFOs, egress
// receive FSMs, sticky misroute detection and saturating drop counters.
//
//   state    | meaning
//   RX_EMPTY | no packet held for the host; pop whenever the mesh has one
//   RX_FULL  | rx_data_o holds a packet; pop again only if the host is ready
module mesh_term_if_bank
   import mesh_term_pkg::*;
#(
   parameter  int ROWS       = 4,
   parameter  int COLUMNS    = 4,
   parameter  int PAKG_SIZE  = 32,
   parameter  int FIFO_DEPTH = 16,
   parameter  int AF_LEVEL   = FIFO_DEPTH - 2,
   localparam int NUM_TERM   = 2*(ROWS + COLUMNS)
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_TERM-1:0]                 push_i,
   input  logic [NUM_TERM-1:0][PAKG_SIZE-1:0]  push_data_i,
   output logic [NUM_TERM-1:0]                 full_o,
   output logic [NUM_TERM-1:0]                 almost_full_o,
   output logic [NUM_TERM-1:0]                 pndng_i_in_o,
   output logic [NUM_TERM-1:0][PAKG_SIZE-1:0]  data_out_i_in_o,
   input  logic [NUM_TERM-1:0]                 popin_i,
   input  logic [NUM_TERM-1:0]                 pndng_i,
   input  logic [NUM_TERM-1:0][PAKG_SIZE-1:0]  data_out_i,
   output logic [NUM_TERM-1:0]                 pop_o,
   output logic [NUM_TERM-1:0]                 rx_valid_o,
   output logic [NUM_TERM-1:0][PAKG_SIZE-1:0]  rx_data_o,
   input  logic [NUM_TERM-1:0]                 rx_ready_i,
   output logic [NUM_TERM-1:0]                 rx_misroute_o,
   output logic [NUM_TERM-1:0][15:0]           drop_cnt_o
);

   localparam int P = PAKG_SIZE;

   for (genvar t = 0; t < NUM_TERM; t++) begin : g_term
      localparam coord_t TC = term_coord(t, ROWS, COLUMNS);

      logic                 w_drop;
      logic                 w_pop;
      logic                 w_misroute;
      logic [P-1:0]         w_pkt;
      rx_state_e            r_state;
      logic [P-1:0]         r_rx_data;
      logic                 r_misroute;
      logic [15:0]          r_drop_cnt;

      mesh_term_fifo #(
         .PAKG_SIZE  (PAKG_SIZE),
         .FIFO_DEPTH (FIFO_DEPTH),
         .AF_LEVEL   (AF_LEVEL)
      ) u_fifo (
         .clk_i         (clk_i),
         .rst_i         (rst_i),
         .push_i        (push_i[t]),
         .data_i        (push_data_i[t]),
         .pop_i         (popin_i[t]),
         .pndng_o       (pndng_i_in_o[t]),
         .data_o        (data_out_i_in_o[t]),
         .full_o        (full_o[t]),
         .almost_full_o (almost_full_o[t]),
         .drop_o        (w_drop)
      );

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            r_drop_cnt <= '0;
         end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end

      // Reset gating keeps the mesh from losing a packet to a bank in reset.
      assign w_pop = rst_i & pndng_i[t] & ((r_state == RX_EMPTY) | rx_ready_i[t]);
      assign w_pkt = data_out_i[t];

      assign w_misroute = (w_pkt[P-1-NXT_JMP_OFS -: NXT_JMP_W] != BCAST_JMP) &&
                          ((w_pkt[P-1-ROW_OFS -: ROW_W] != TC.row) ||
                           (w_pkt[P-1-COL_OFS -: COL_W] != TC.col));

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            r_state    <= RX_EMPTY;
            r_rx_data  <= '0;
            r_misroute <= 1'b0;
         end else if (w_pop) begin
            r_state   <= RX_FULL;
            r_rx_data <= w_pkt;
            if (w_misroute) r_misroute <= 1'b1;
         end else if (rx_ready_i[t] && (r_state == RX_FULL)) begin
            r_state <= RX_EMPTY;
         end
      end

      assign pop_o[t]         = w_pop;
      assign rx_valid_o[t]    = (r_state == RX_FULL);
      assign rx_data_o[t]     = r_rx_data;
      assign rx_misroute_o[t] = r_misroute;
      assign drop_cnt_o[t]    = r_drop_cnt;
   end

endmodule

// File: tb/tb_mesh_term_if_bank.sv
// Self-checking bench for mesh_term_if_bank: queue-based reference model,
// directed corner sequences, a misroute vector table and random traffic.
module tb_mesh_term_if_bank;

   localparam int NT = 16;
   localparam int D  = 16;
   localparam int AF = 14;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic [NT-1:0]        push_i;
   logic [NT-1:0][31:0]  push_data_i;
   logic [NT-1:0]        full_o;
   logic [NT-1:0]        almost_full_o;
   logic [NT-1:0]        pndng_i_in_o;
   logic [NT-1:0][31:0]  data_out_i_in_o;
   logic [NT-1:0]        popin_i;
   logic [NT-1:0]        pndng_i;
   logic [NT-1:0][31:0]  data_out_i;
   logic [NT-1:0]        pop_o;
   logic [NT-1:0]        rx_valid_o;
   logic [NT-1:0][31:0]  rx_data_o;
   logic [NT-1:0]        rx_ready_i;
   logic [NT-1:0]        rx_misroute_o;
   logic [NT-1:0][15:0]  drop_cnt_o;

   always #5 clk = ~clk;

   mesh_term_if_bank dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .push_i          (push_i),
      .push_data_i     (push_data_i),
      .full_o          (full_o),
      .almost_full_o   (almost_full_o),
      .pndng_i_in_o    (pndng_i_in_o),
      .data_out_i_in_o (data_out_i_in_o),
      .popin_i         (popin_i),
      .pndng_i         (pndng_i),
      .data_out_i      (data_out_i),
      .pop_o           (pop_o),
      .rx_valid_o      (rx_valid_o),
      .rx_data_o       (rx_data_o),
      .rx_ready_i      (rx_ready_i),
      .rx_misroute_o   (rx_misroute_o),
      .drop_cnt_o      (drop_cnt_o)
   );

   // Terminal coordinates for the default 4x4 mesh, written out by hand.
   int row_tab [NT] = '{0,0,0,0, 5,5,5,5, 1,2,3,4, 1,2,3,4};
   int col_tab [NT] = '{1,2,3,4, 1,2,3,4, 0,0,0,0, 5,5,5,5};

   logic [31:0] mq [NT][$];
   int          mdrop [NT];
   bit          mv    [NT];
   logic [31:0] md    [NT];
   bit          mmis  [NT];

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int         term;
      logic [7:0] nj;
      logic [3:0] row;
      logic [3:0] col;
      bit         exp_mis;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] nj, input logic [3:0] row,
                                      input logic [3:0] col, input int pay);
      logic [14:0] p;
      p = pay[14:0];
      return {nj, row, col, 1'b0, p};
   endfunction

   function automatic bit misr(input int t, input logic [31:0] d);
      if (d[31:24] == 8'hFF) return 1'b0;
      return (int'(d[23:20]) != row_tab[t]) || (int'(d[19:16]) != col_tab[t]);
   endfunction

   task automatic model_reset();
      for (int t = 0; t < NT; t++) begin
         mq[t].delete();
         mdrop[t] = 0;
         mv[t]    = 1'b0;
         md[t]    = '0;
         mmis[t]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      int n;
      bit popok;
      for (int t = 0; t < NT; t++) begin
         n     = mq[t].size();
         popok = popin_i[t] && (n > 0);
         if (popok) void'(mq[t].pop_front());
         if (push_i[t]) begin
            if (n < D || popok) mq[t].push_back(push_data_i[t]);
            else if (mdrop[t] < 65535) mdrop[t]++;
         end
         if (pndng_i[t] && (!mv[t] || rx_ready_i[t])) begin
            mv[t] = 1'b1;
            md[t] = data_out_i[t];
            if (misr(t, data_out_i[t])) mmis[t] = 1'b1;
         end else if (rx_ready_i[t]) begin
            mv[t] = 1'b0;
         end
      end
   endtask

   task automatic check_state();
      logic [NT-1:0] e_pnd, e_full, e_af, e_v, e_mis;
      for (int t = 0; t < NT; t++) begin
         e_pnd[t]  = (mq[t].size() != 0);
         e_full[t] = (mq[t].size() == D);
         e_af[t]   = (mq[t].size() >= AF);
         e_v[t]    = mv[t];
         e_mis[t]  = mmis[t];
      end
      chk("pndng_i_in_o", pndng_i_in_o, e_pnd);
      chk("full_o", full_o, e_full);
      chk("almost_full_o", almost_full_o, e_af);
      chk("rx_valid_o", rx_valid_o, e_v);
      chk("rx_misroute_o", rx_misroute_o, e_mis);
      for (int t = 0; t < NT; t++) begin
         if (mq[t].size() != 0)
            chk($sformatf("head[%0d]", t), data_out_i_in_o[t], mq[t][0]);
         chk($sformatf("drop_cnt[%0d]", t), drop_cnt_o[t], mdrop[t]);
         chk($sformatf("rx_data[%0d]", t), rx_data_o[t], md[t]);
      end
   endtask

   task automatic tick();
      logic [NT-1:0] e_pop;
      #1;
      for (int t = 0; t < NT; t++) e_pop[t] = pndng_i[t] && (!mv[t] || rx_ready_i[t]);
      chk("pop_o", pop_o, e_pop);
      model_edge();
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic clear_inputs();
      push_i      = '0;
      push_data_i = '0;
      popin_i     = '0;
      pndng_i     = '0;
      data_out_i  = '0;
      rx_ready_i  = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i   = 1'b0;
      pndng_i = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("pop_in_reset", pop_o, '0);
      check_state();
      pndng_i = '0;
      rst_i   = 1'b1;
   endtask

   initial begin
      int delivered;
      int pop_hits;
      logic [31:0] base;

      vt[0]  = '{3,  8'h01, 4'd0, 4'd4, 1'b0};
      vt[1]  = '{3,  8'h01, 4'd2, 4'd2, 1'b1};
      vt[2]  = '{3,  8'hFF, 4'd2, 4'd2, 1'b0};
      vt[3]  = '{0,  8'h10, 4'd0, 4'd1, 1'b0};
      vt[4]  = '{0,  8'h10, 4'd0, 4'd2, 1'b1};
      vt[5]  = '{5,  8'h00, 4'd5, 4'd2, 1'b0};
      vt[6]  = '{9,  8'h22, 4'd2, 4'd0, 1'b0};
      vt[7]  = '{9,  8'h22, 4'd2, 4'd1, 1'b1};
      vt[8]  = '{14, 8'h22, 4'd3, 4'd5, 1'b0};
      vt[9]  = '{14, 8'hFE, 4'd3, 4'd4, 1'b1};
      vt[10] = '{12, 8'hFF, 4'd0, 4'd0, 1'b0};

      do_reset();
      chk("af_after_reset", almost_full_o, '0);

      // Fill terminal 0, then overflow once.
      base = 32'hA000_0000;
      for (int k = 0; k < 16; k++) begin
         push_i[0] = 1'b1;
         push_data_i[0] = base + k;
         tick();
      end
      chk("full_after_16", full_o[0], 1'b1);
      push_data_i[0] = base + 16;
      tick();
      chk("drop_after_17", drop_cnt_o[0], 16'd1);
      chk("head_after_drop", data_out_i_in_o[0], base);

      // Push and pop together while full, then keep wrapping.
      popin_i[0] = 1'b1;
      push_data_i[0] = base + 17;
      tick();
      chk("full_stays", full_o[0], 1'b1);
      chk("second_head", data_out_i_in_o[0], base + 1);
      for (int k = 0; k < 40; k++) begin
         push_data_i[0] = base + 18 + k;
         tick();
      end
      chk("wrap_head", data_out_i_in_o[0], base + 42);
      chk("wrap_full", full_o[0], 1'b1);

      // Egress hold-off on terminal 3 until the host is ready.
      do_reset();
      pndng_i[3] = 1'b1;
      data_out_i[3] = mk(8'h03, 4'd0, 4'd4, 7);
      #1;
      chk("pop_first", pop_o[3], 1'b1);
      tick();
      chk("rx_valid_next", rx_valid_o[3], 1'b1);
      for (int k = 0; k < 3; k++) begin
         data_out_i[3] = mk(8'h03, 4'd0, 4'd4, 8 + k);
         tick();
         chk("no_pop_not_ready", pop_o[3], 1'b0);
      end
      chk("rx_data_held", rx_data_o[3], mk(8'h03, 4'd0, 4'd4, 7));
      rx_ready_i[3] = 1'b1;
      #1;
      chk("pop_when_ready", pop_o[3], 1'b1);
      tick();
      chk("rx_data_next", rx_data_o[3], mk(8'h03, 4'd0, 4'd4, 10));

      // Misroute table.
      for (int i = 0; i < 11; i++) begin
         do_reset();
         pndng_i[vt[i].term] = 1'b1;
         data_out_i[vt[i].term] = mk(vt[i].nj, vt[i].row, vt[i].col, i);
         tick();
         chk($sformatf("vec%0d_valid", i), rx_valid_o[vt[i].term], 1'b1);
         chk($sformatf("vec%0d_misroute", i), rx_misroute_o[vt[i].term], vt[i].exp_mis);
         chk($sformatf("vec%0d_data", i), rx_data_o[vt[i].term], mk(vt[i].nj, vt[i].row, vt[i].col, i));
      end

      // Asynchronous reset in the middle of a burst.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         push_i[2] = 1'b1;
         push_data_i[2] = 32'h5500_0000 + k;
         pndng_i[5] = (k == 0);
         data_out_i[5] = mk(8'h01, 4'd5, 4'd2, k);
         tick();
      end
      chk("five_queued", pndng_i_in_o[2], 1'b1);
      pndng_i[5] = 1'b1;
      rst_i = 1'b0;
      #1;
      chk("rst_pndng_now", pndng_i_in_o, '0);
      chk("rst_valid_now", rx_valid_o, '0);
      chk("rst_pop_now", pop_o, '0);
      chk("rst_full_now", full_o, '0);
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      tick();
      chk("no_replay", pndng_i_in_o[2], 1'b0);

      // Streaming egress at one packet per cycle.
      do_reset();
      pndng_i[7] = 1'b1;
      rx_ready_i[7] = 1'b1;
      delivered = 0;
      pop_hits = 0;
      for (int k = 0; k < 100; k++) begin
         data_out_i[7] = mk(8'h07, 4'd5, 4'd4, k);
         #1;
         if (pop_o[7]) pop_hits++;
         tick();
         if (rx_data_o[7] == mk(8'h07, 4'd5, 4'd4, k) && rx_valid_o[7]) delivered++;
      end
      chk("stream_pops", pop_hits, 100);
      chk("stream_in_order", delivered, 100);

      // Random traffic against the model.
      do_reset();
      for (int k = 0; k < 800; k++) begin
         for (int t = 0; t < NT; t++) begin
            push_i[t]      = ($urandom_range(0, 9) < 7);
            popin_i[t]     = ($urandom_range(0, 9) < 3);
            pndng_i[t]     = $urandom_range(0, 1) == 1;
            rx_ready_i[t]  = $urandom_range(0, 1) == 1;
            push_data_i[t] = $urandom;
            data_out_i[t]  = ($urandom_range(0, 3) == 0) ?
                             mk(8'h01, row_tab[t][3:0], col_tab[t][3:0], k) : $urandom;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
